// File: rtl/prach_conv_sched.sv
// prach_conv_sched: per-channel phase scheduler for the PRACH TDM frequency-shift mixer.
// Walks channel slots aligned to sync_in and emits each slot's pre-update accumulator phase.

module prach_conv_chan #(
    parameter int PhaseWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [31:0]           wr_data,
    input  logic                  apply,
    input  logic                  step,
    output logic [PhaseWidth-1:0] phase
);
    logic [31:0] shadow;
    logic [31:0] active;
    logic [31:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            acc    <= '0;
        end else begin
            if (wr) shadow <= wr_data;
            if (apply) begin
                active <= shadow;
                // The slot emitted on the apply edge shows phase 0 and still advances once this period.
                acc    <= step ? shadow : 32'd0;
            end else if (step) begin
                acc <= acc + active;
            end
        end
    end

    assign phase = acc[31 -: PhaseWidth];
endmodule

module prach_conv_sched #(
    parameter int NumChannels = 12,
    parameter int PhaseWidth  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_in,
    input  logic                  cfg_wr,
    input  logic [7:0]            cfg_addr,
    input  logic [31:0]           cfg_fcw,
    input  logic                  cfg_commit,
    output logic                  cfg_busy,
    input  logic                  err_clr,
    output logic                  err_sync,
    output logic                  err_addr,
    output logic [7:0]            dout_chn,
    output logic [PhaseWidth-1:0] dout_phase,
    output logic                  dout_valid,
    output logic                  sync_out
);
    localparam logic [7:0] LastSlot = 8'(NumChannels - 1);
    localparam logic [8:0] NumCh9   = 9'(NumChannels);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                                 state;
    logic   [7:0]                           cnt;
    logic   [7:0]                           slot_next;
    logic                                   pending;
    logic                                   running;
    logic                                   emit;
    logic                                   apply;
    logic                                   addr_ok;
    logic   [NumChannels-1:0][PhaseWidth-1:0] phase;
    logic   [PhaseWidth-1:0]                phase_sel;

    assign running  = (state == RUN);
    assign emit     = running || sync_in;
    assign apply    = running && sync_in && pending;
    assign addr_ok  = {1'b0, cfg_addr} < NumCh9;
    assign cfg_busy = pending;
    assign dout_chn = cnt;

    always_comb begin
        if (sync_in || cnt == LastSlot) slot_next = 8'd0;
        else                            slot_next = cnt + 8'd1;
    end

    genvar i;
    generate
        for (i = 0; i < NumChannels; i++) begin : g_chan
            prach_conv_chan #(
                .PhaseWidth(PhaseWidth)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .wr     (cfg_wr && cfg_addr == 8'(i)),
                .wr_data(cfg_fcw),
                .apply  (apply),
                .step   (emit && slot_next == 8'(i)),
                .phase  (phase[i])
            );
        end
    endgenerate

    always_comb begin
        phase_sel = '0;
        for (int k = 0; k < NumChannels; k++)
            if (slot_next == 8'(k)) phase_sel = phase[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            dout_phase <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            pending    <= 1'b0;
            err_sync   <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            // A commit that lands with the sync it would ride on waits for the following sync.
            if (apply)           pending <= 1'b0;
            else if (cfg_commit) pending <= 1'b1;

            err_sync <= (running && sync_in && cnt != LastSlot) || (err_sync && !err_clr);
            err_addr <= (cfg_wr && !addr_ok) || (err_addr && !err_clr);

            case (state)
                IDLE: begin
                    if (sync_in) begin
                        state      <= RUN;
                        cnt        <= 8'd0;
                        dout_phase <= phase_sel;
                        dout_valid <= 1'b1;
                        sync_out   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt        <= slot_next;
                    dout_phase <= apply ? '0 : phase_sel;
                    dout_valid <= 1'b1;
                    sync_out   <= sync_in;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prach_conv_sched.sv
// Directed bench for prach_conv_sched with NumChannels=4, PhaseWidth=16.
module tb_prach_conv_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        sync_in;
    logic        cfg_wr;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_fcw;
    logic        cfg_commit;
    logic        cfg_busy;
    logic        err_clr;
    logic        err_sync;
    logic        err_addr;
    logic [7:0]  dout_chn;
    logic [15:0] dout_phase;
    logic        dout_valid;
    logic        sync_out;

    int checks = 0;
    int errors = 0;

    prach_conv_sched #(.NumChannels(4), .PhaseWidth(16)) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_fcw(cfg_fcw),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .err_clr(err_clr), .err_sync(err_sync), .err_addr(err_addr),
        .dout_chn(dout_chn), .dout_phase(dout_phase),
        .dout_valid(dout_valid), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    // One clock: pulse inputs set by the caller are dropped after the edge.
    task automatic step(input logic s);
        sync_in = s;
        @(posedge clk);
        #1;
        sync_in    = 1'b0;
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_in = 0; cfg_wr = 0; cfg_addr = 0; cfg_fcw = 0;
        cfg_commit = 0; err_clr = 0;
        #1;
        checks++;
        if ({dout_valid, sync_out, dout_chn, dout_phase, cfg_busy, err_sync, err_addr} !== 29'd0) begin
            errors++;
            $display("FAIL reset: valid=%b sync_out=%b chn=%0d phase=%h busy=%b errs=%b%b, required all 0",
                     dout_valid, sync_out, dout_chn, dout_phase, cfg_busy, err_sync, err_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step(1'b0);
            checks++;
            if ({dout_valid, sync_out, dout_chn, dout_phase} !== 26'd0) begin
                errors++;
                $display("FAIL idle c%0d: valid=%b sync_out=%b chn=%0d phase=%h, required 0 0 0 0000",
                         c, dout_valid, sync_out, dout_chn, dout_phase);
            end
        end
    endtask

    task automatic test_basic_sweep();
        logic [15:0] tbl [4][4];
        tbl = '{'{16'h0, 16'h0, 16'h0, 16'h0},
                '{16'h0, 16'h0, 16'h0, 16'h0},
                '{16'h0, 16'h0001, 16'h8000, 16'h0},
                '{16'h0, 16'h0002, 16'h0000, 16'h0}};
        cfg_wr = 1; cfg_addr = 8'd1; cfg_fcw = 32'h0001_0000; step(1'b0);
        cfg_wr = 1; cfg_addr = 8'd2; cfg_fcw = 32'h8000_0000; step(1'b0);
        cfg_commit = 1; step(1'b0);
        checks++;
        if (cfg_busy !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep commit: busy=%b valid=%b, required 1 0", cfg_busy, dout_valid);
        end
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) begin
                step(k == 0);
                checks++;
                if (dout_chn !== 8'(k) || sync_out !== (k == 0) || dout_valid !== 1'b1 ||
                    dout_phase !== tbl[p][k] || cfg_busy !== (p == 0)) begin
                    errors++;
                    $display("FAIL sweep p%0d s%0d: chn=%0d sync_out=%b valid=%b phase=%h busy=%b, required %0d %b 1 %h %b",
                             p, k, dout_chn, sync_out, dout_valid, dout_phase, cfg_busy,
                             k, k == 0, tbl[p][k], p == 0);
                end
            end
    endtask

    task automatic test_commit_timing();
        logic [15:0] tbl [3][4];
        tbl = '{'{16'h0, 16'h0003, 16'h8000, 16'h0},
                '{16'h0, 16'h0, 16'h0, 16'h0},
                '{16'h0, 16'h0002, 16'h8000, 16'h0}};
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 4; k++) begin
                if (p == 0 && k == 0) begin
                    cfg_wr = 1; cfg_addr = 8'd1; cfg_fcw = 32'h0002_0000; cfg_commit = 1;
                end
                step(k == 0);
                checks++;
                if (dout_chn !== 8'(k) || sync_out !== (k == 0) ||
                    dout_phase !== tbl[p][k] || cfg_busy !== (p == 0)) begin
                    errors++;
                    $display("FAIL commit p%0d s%0d: chn=%0d sync_out=%b phase=%h busy=%b, required %0d %b %h %b",
                             p, k, dout_chn, sync_out, dout_phase, cfg_busy,
                             k, k == 0, tbl[p][k], p == 0);
                end
            end
    endtask

    task automatic test_misaligned();
        step(1'b0);
        checks++;
        if (dout_chn !== 8'd0 || sync_out !== 1'b0 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL wrap no sync: chn=%0d sync_out=%b err_sync=%b, required 0 0 0",
                     dout_chn, sync_out, err_sync);
        end
        step(1'b0);
        step(1'b1);
        checks++;
        if (dout_chn !== 8'd0 || sync_out !== 1'b1 || err_sync !== 1'b1) begin
            errors++;
            $display("FAIL misaligned sync: chn=%0d sync_out=%b err_sync=%b, required 0 1 1",
                     dout_chn, sync_out, err_sync);
        end
        step(1'b0);
        checks++;
        if (dout_chn !== 8'd1 || err_sync !== 1'b1) begin
            errors++;
            $display("FAIL err_sync held: chn=%0d err_sync=%b, required 1 1", dout_chn, err_sync);
        end
        step(1'b0);
        err_clr = 1; step(1'b0);
        checks++;
        if (dout_chn !== 8'd3 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: chn=%0d err_sync=%b, required 3 0", dout_chn, err_sync);
        end
        step(1'b1);
        checks++;
        if (dout_chn !== 8'd0 || sync_out !== 1'b1 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL on-boundary sync: chn=%0d sync_out=%b err_sync=%b, required 0 1 0",
                     dout_chn, sync_out, err_sync);
        end
        step(1'b0);
        err_clr = 1; step(1'b1);
        checks++;
        if (dout_chn !== 8'd0 || err_sync !== 1'b1) begin
            errors++;
            $display("FAIL set beats clear: chn=%0d err_sync=%b, required 0 1", dout_chn, err_sync);
        end
        err_clr = 1; step(1'b0);
        checks++;
        if (dout_chn !== 8'd1 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL second clear: chn=%0d err_sync=%b, required 1 0", dout_chn, err_sync);
        end
    endtask

    task automatic test_bad_address();
        logic [15:0] tbl [2][4];
        tbl = '{'{16'h0, 16'h0, 16'h0, 16'h0},
                '{16'h0, 16'h0002, 16'h8000, 16'h0}};
        cfg_wr = 1; cfg_addr = 8'd4; cfg_fcw = 32'hFFFF_FFFF; step(1'b0);
        checks++;
        if (err_addr !== 1'b1 || err_sync !== 1'b0 || dout_chn !== 8'd2) begin
            errors++;
            $display("FAIL bad addr: err_addr=%b err_sync=%b chn=%0d, required 1 0 2",
                     err_addr, err_sync, dout_chn);
        end
        cfg_commit = 1; step(1'b0);
        checks++;
        if (cfg_busy !== 1'b1 || dout_chn !== 8'd3) begin
            errors++;
            $display("FAIL bad addr commit: busy=%b chn=%0d, required 1 3", cfg_busy, dout_chn);
        end
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++) begin
                step(k == 0);
                checks++;
                if (dout_chn !== 8'(k) || dout_phase !== tbl[p][k] || cfg_busy !== 1'b0 ||
                    err_addr !== 1'b1) begin
                    errors++;
                    $display("FAIL shadow kept p%0d s%0d: chn=%0d phase=%h busy=%b err_addr=%b, required %0d %h 0 1",
                             p, k, dout_chn, dout_phase, cfg_busy, err_addr, k, tbl[p][k]);
                end
            end
        err_clr = 1; step(1'b0);
        checks++;
        if (err_addr !== 1'b0) begin
            errors++;
            $display("FAIL err_addr clear: err_addr=%b, required 0", err_addr);
        end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            checks++;
            if (dout_chn !== 8'((i + 1) % 4) || sync_out !== 1'b0 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL free run %0d: chn=%0d sync_out=%b valid=%b, required %0d 0 1",
                         i, dout_chn, sync_out, dout_valid, (i + 1) % 4);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout_valid, sync_out, dout_chn, dout_phase, cfg_busy} !== 27'd0) begin
            errors++;
            $display("FAIL async reset: valid=%b sync_out=%b chn=%0d phase=%h busy=%b, required all 0",
                     dout_valid, sync_out, dout_chn, dout_phase, cfg_busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            checks++;
            if (dout_valid !== 1'b0 || dout_chn !== 8'd0) begin
                errors++;
                $display("FAIL post-reset idle %0d: valid=%b chn=%0d, required 0 0", c, dout_valid, dout_chn);
            end
        end
        step(1'b1);
        checks++;
        if (dout_valid !== 1'b1 || sync_out !== 1'b1 || dout_chn !== 8'd0 || dout_phase !== 16'h0) begin
            errors++;
            $display("FAIL restart: valid=%b sync_out=%b chn=%0d phase=%h, required 1 1 0 0000",
                     dout_valid, sync_out, dout_chn, dout_phase);
        end
        step(1'b0);
        checks++;
        if (dout_chn !== 8'd1 || dout_phase !== 16'h0) begin
            errors++;
            $display("FAIL restart acc cleared: chn=%0d phase=%h, required 1 0000", dout_chn, dout_phase);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_commit_timing();
        test_misaligned();
        test_bad_address();
        test_free_run();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prach_conv_sched.md
Name: prach_conv_sched

Overview:
- Per-channel phase scheduler for the PRACH TDM frequency-shift mixer.
- Holds one 32-bit frequency control word (FCW) and one phase accumulator per TDM channel.
- Walks the channel slots aligned to sync_in and emits, each cycle, the channel index and the 16-bit phase for the NCO/complex-multiplier stage.
- Software-written FCWs are double-buffered and take effect atomically at a sync boundary.

Parameters:
- NumChannels, 12, number of TDM channel slots per period (1..256).
- PhaseWidth, 16, width of the emitted phase (MSBs of the 32-bit accumulator).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- sync_in  in  1  marks the cycle preceding channel-0 slot.
- cfg_wr  in  1  write strobe for the shadow FCW table.
- cfg_addr  in  8  channel index for cfg_wr.
- cfg_fcw  in  32  FCW data for cfg_wr.
- cfg_commit  in  1  request to copy shadow to active at the next sync.
- cfg_busy  out  1  commit pending.
- err_clr  in  1  clears sticky errors.
- err_sync  out  1  sticky: sync_in arrived off period boundary.
- err_addr  out  1  sticky: cfg_wr with cfg_addr >= NumChannels.
- dout_chn  out  8  current channel slot.
- dout_phase  out  PhaseWidth  phase for dout_chn.
- dout_valid  out  1  scheduler running.
- sync_out  out  1  high with channel-0 slot.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; all FCWs 0 (shadow and active); all accumulators 0; commit pending cleared.
- States:
  - IDLE: dout_valid=0, counter held at 0, outputs 0.
  - IDLE -> RUN on the first sync_in.
  - RUN persists until reset.
- RUN counter cnt:
  - sync_in=1 forces next cnt=0.
  - Otherwise cnt increments and wraps NumChannels-1 -> 0 (free-running without sync).
- All outputs registered, latency 1 from sync_in: sync_in at cycle t gives dout_chn=0, sync_out=1, dout_valid=1 at t+1.
- Per slot k in RUN:
  - dout_phase = acc[k][31:32-PhaseWidth], the pre-update value.
  - acc[k] <= acc[k] + fcw_active[k], mod 2^32 wrap, no saturation.
  - Each channel's accumulator advances once per period.
- sync_out is high only in the slot following sync_in; automatic wrap to 0 does not assert it.
- err_sync is set when sync_in=1 in RUN with cnt != NumChannels-1; the counter realigns regardless.
- cfg_wr:
  - addr < NumChannels: shadow[addr] <= cfg_fcw.
  - Otherwise the write is ignored and err_addr is set.
- Commit:
  - cfg_commit sets pending; cfg_busy = pending.
  - On the next sync_in with pending already set: active <= shadow for all channels, all accumulators <= 0, pending cleared.
  - The channel-0 slot at t+1 then outputs phase 0.
- Simultaneous events:
  - cfg_commit on the same cycle as sync_in: not applied on that sync; pending set for the following sync.
  - cfg_wr on the same cycle as an applying sync: goes to shadow only and is not included in that commit.
  - cfg_commit while pending: no effect.
  - err_clr with a new error event: set wins.
- NumChannels=1: cnt stays 0; every sync_in is on-boundary.
- Reset mid-operation returns to IDLE immediately; restart requires sync_in.

Test Plan:
- Reset then idle: no sync_in for 50 cycles -> dout_valid=0, dout_chn=0, dout_phase=0, sync_out=0.
- Basic sweep:
  - Stimulus: NumChannels=4; write shadow[1]=0x0001_0000, shadow[2]=0x8000_0000; commit; sync_in at t0, then every 4 cycles.
  - Second sync yields (the first sync only starts RUN): chn sequence 0,1,2,3 with sync_out only on chn 0; all phases 0.
  - Next period: chn1 phase 0x0001, chn2 phase 0x8000.
  - Period after: chn2 phase 0x0000 (wrap), chn1 phase 0x0002.
- Commit timing: FCWs active; write new shadow[1]=0x0002_0000 and cfg_commit on the same cycle as sync_in.
  - cfg_busy=1 through that period and old FCW still used.
  - On the next sync, chn1 phase restarts at 0, then 0x0002; cfg_busy falls.
- Misaligned sync:
  - Stimulus: NumChannels=4; sync_in when cnt=1.
  - Next cycle chn=0 with sync_out=1; err_sync=1 and held.
  - err_clr clears it; on-boundary syncs do not set it.
- Bad address: cfg_wr with cfg_addr=4 (NumChannels=4) -> err_addr=1, shadow table unchanged (verified after commit).
- Free-run and async reset:
  - Stop sync_in: chn keeps cycling 0..3 and sync_out stays 0.
  - Assert rst mid-period: outputs 0 and dout_valid=0 in the same cycle without a clock edge.
